// File: rtl/icache_pkg.sv
// icache_pkg: shared state encoding and Wishbone constants for the icache refill controller
package icache_pkg;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BURST  = 3'd1,
        ST_RETRY  = 3'd2,
        ST_WRITE  = 3'd3,
        ST_SETTLE = 3'd4
    } state_t;
    localparam logic [2:0] WB_CTI_INCR   = 3'b010;
    localparam logic [2:0] WB_CTI_EOB    = 3'b111;
    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [1:0] WB_BTE_LINEAR = 2'b00;
    localparam logic [3:0] WB_SEL_ALL    = 4'hF;
endpackage

// File: rtl/icache_refill_ctrl_if.sv
// icache_refill_ctrl_if: Wishbone read-burst bus between the refill controller and the memory slave
//   master: drives wb_cyc_o/wb_stb_o/wb_we_o/wb_adr_o/wb_cti_o/wb_bte_o/wb_sel_o, samples wb_ack_i/wb_err_i/wb_rty_i/wb_dat_i
//   slave:  the mirror image
interface icache_refill_ctrl_if #(parameter int ADDR_W = 32);
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [ADDR_W-1:0] wb_adr_o;
    logic [2:0]        wb_cti_o;
    logic [1:0]        wb_bte_o;
    logic [3:0]        wb_sel_o;
    logic              wb_ack_i;
    logic              wb_err_i;
    logic              wb_rty_i;
    logic [31:0]       wb_dat_i;
    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_cti_o, wb_bte_o, wb_sel_o,
        input  wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i
    );
    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_cti_o, wb_bte_o, wb_sel_o,
        output wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i
    );
endinterface

// File: rtl/icache_line_buf.sv
// icache_line_buf: word-write-enabled line assembly register
//   clk, rst_n (async active-high clear), we (write word idx), idx (word index), din (word), line (all words, word i at [32*i+:32])
module icache_line_buf #(
    parameter int LINE_WORDS = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          we,
    input  logic [$clog2(LINE_WORDS)-1:0] idx,
    input  logic [31:0]                   din,
    output logic [32*LINE_WORDS-1:0]      line
);
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) line <= '0;
        else if (we) line[32*idx +: 32] <= din;
    end
endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: instruction-cache miss sequencer doing a Wishbone burst line refill
//   clk, rst_n (async active-high reset), miss_req/miss_paddr (miss request), kill (abandon refill),
//   wb (Wishbone master), line_data/line_we (cache line write), freeze (fetch stall),
//   refill_done/refill_err (completion pulses)
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 32,
    parameter int RETRY_MAX  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     miss_req,
    input  logic [ADDR_W-1:0]        miss_paddr,
    input  logic                     kill,
    icache_refill_ctrl_if.master     wb,
    output logic [32*LINE_WORDS-1:0] line_data,
    output logic                     line_we,
    output logic                     freeze,
    output logic                     refill_done,
    output logic                     refill_err
);
    localparam int BW  = $clog2(LINE_WORDS);
    localparam int OFF = BW + 2;
    localparam int RW  = $clog2(RETRY_MAX + 1);
    localparam logic [BW-1:0] LAST = BW'(LINE_WORDS - 1);

    state_t              state, nxt;
    logic [BW-1:0]       beat, beat_n;
    logic [RW-1:0]       retry, retry_n;
    logic [ADDR_W-OFF-1:0] tag, tag_n;
    logic                wr;
    logic                rty_spent;
    logic                unused_ok;

    assign unused_ok = ^miss_paddr[OFF-1:0];
    assign rty_spent = retry == RW'(RETRY_MAX);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= ST_IDLE;
            beat  <= '0;
            retry <= '0;
            tag   <= '0;
        end else begin
            state <= nxt;
            beat  <= beat_n;
            retry <= retry_n;
            tag   <= tag_n;
        end
    end

    // err beats kill, kill beats rty/ack; refill_err is raised in the BURST cycle itself
    // so freeze drops the cycle after the pulse
    always_comb begin
        nxt        = state;
        beat_n     = beat;
        retry_n    = retry;
        tag_n      = tag;
        wr         = 1'b0;
        refill_err = 1'b0;
        case (state)
            ST_IDLE: if (miss_req) begin
                nxt     = ST_BURST;
                tag_n   = miss_paddr[ADDR_W-1:OFF];
                beat_n  = '0;
                retry_n = '0;
            end
            ST_BURST:
                if (wb.wb_err_i) begin
                    refill_err = 1'b1;
                    nxt        = ST_IDLE;
                end else if (kill) begin
                    nxt = ST_IDLE;
                end else if (wb.wb_rty_i) begin
                    refill_err = rty_spent;
                    retry_n    = retry + RW'(1);
                    nxt        = rty_spent ? ST_IDLE : ST_RETRY;
                end else if (wb.wb_ack_i) begin
                    wr     = 1'b1;
                    beat_n = beat + BW'(1);
                    nxt    = beat == LAST ? ST_WRITE : ST_BURST;
                end
            ST_RETRY: begin
                beat_n = '0;
                nxt    = ST_BURST;
            end
            ST_WRITE: nxt = ST_SETTLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    // bus outputs decode only registered state, so they never glitch with slave inputs
    assign wb.wb_cyc_o = state == ST_BURST;
    assign wb.wb_stb_o = state == ST_BURST;
    assign wb.wb_we_o  = 1'b0;
    assign wb.wb_adr_o = {tag, beat, 2'b00};
    assign wb.wb_cti_o = state != ST_BURST ? WB_CTI_CLASSIC : beat == LAST ? WB_CTI_EOB : WB_CTI_INCR;
    assign wb.wb_bte_o = WB_BTE_LINEAR;
    assign wb.wb_sel_o = WB_SEL_ALL;
    assign line_we     = state == ST_WRITE;
    assign refill_done = state == ST_SETTLE;
    assign freeze      = state != ST_IDLE || miss_req;

    icache_line_buf #(.LINE_WORDS(LINE_WORDS)) u_line_buf (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (wr),
        .idx  (beat),
        .din  (wb.wb_dat_i),
        .line (line_data)
    );
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: randomized scoreboard bench for icache_refill_ctrl with a transaction-level reference model
module tb_icache_refill_ctrl;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         miss_req = 1'b0;
    logic [31:0]  miss_paddr = '0;
    logic         kill = 1'b0;
    logic [255:0] line_data;
    logic         line_we, freeze, refill_done, refill_err;

    icache_refill_ctrl_if bus ();

    icache_refill_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .miss_req   (miss_req),
        .miss_paddr (miss_paddr),
        .kill       (kill),
        .wb         (bus),
        .line_data  (line_data),
        .line_we    (line_we),
        .freeze     (freeze),
        .refill_done(refill_done),
        .refill_err (refill_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         cyc;
        logic [31:0]  adr;
        logic [2:0]   cti;
        logic         we;
        logic [255:0] line;
        logic         done;
        logic         err;
        logic         frz;
    } exp_t;

    exp_t q[$];
    exp_t e, x;
    int   n_cmp = 0, n_bad = 0;

    // reference model: where the refill is in terms of beats, retries and the write/done tail
    bit          m_bus = 0, m_gap = 0, directed = 1, rst_done = 0;
    int          m_tail = 0, m_beat = 0, m_retry = 0;
    logic [31:0] m_base = '0;
    logic [31:0] m_words[8];
    int          p_err, p_kill, p_rty, p_wait;
    int          n_done = 0, n_err = 0, n_kill = 0;

    function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic new_profile();
        int k;
        k = $urandom_range(0, 3);
        {p_err, p_kill, p_rty, p_wait} = {32'd0, 32'd0, 32'd0, 32'd0};
        if (directed) k = 0;
        if (k == 1) p_wait = 40;
        if (k == 2) {p_err, p_kill, p_rty, p_wait} = {32'd3, 32'd3, 32'd5, 32'd20};
        if (k == 3) {p_rty, p_wait} = {32'd35, 32'd10};
    endtask

    task automatic step();
        bit idle;
        int r;
        idle = !m_bus && !m_gap && m_tail == 0;
        kill = 1'b0;
        miss_req = 1'b0;
        miss_paddr = $urandom;
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
        bus.wb_rty_i = 1'b0;
        bus.wb_dat_i = $urandom;
        if (idle) begin
            miss_req = directed || $urandom_range(0, 99) < 60;
            if (directed) miss_paddr = 32'h0000_1234;
        end else if (m_bus) begin
            if (directed) bus.wb_dat_i = 32'hA0 + 32'(m_beat);
            miss_req = 1'($urandom);
            r = $urandom_range(0, 99);
            if (r < p_err) begin
                bus.wb_err_i = 1'b1;
                bus.wb_ack_i = 1'($urandom);
            end else if (r < p_err + p_kill) begin
                kill = 1'b1;
                bus.wb_ack_i = 1'($urandom);
            end else if (r < p_err + p_kill + p_rty) bus.wb_rty_i = 1'b1;
            else if (r >= p_err + p_kill + p_rty + p_wait) bus.wb_ack_i = 1'b1;
        end else begin
            miss_req = 1'($urandom);
            kill = m_tail != 0 && $urandom_range(0, 2) == 0;
        end
        x.cyc  = m_bus;
        x.adr  = (m_base & ~32'h1F) + 32'(4 * m_beat);
        x.cti  = m_beat == 7 ? 3'b111 : 3'b010;
        x.we   = m_tail == 1;
        x.done = m_tail == 2;
        x.err  = m_bus && (bus.wb_err_i || (!kill && bus.wb_rty_i && m_retry == 3));
        x.frz  = !idle || miss_req;
        for (int i = 0; i < 8; i++) x.line[32*i +: 32] = m_words[i];
        q.push_back(x);
        if (idle) begin
            if (miss_req) begin
                m_bus = 1;
                m_beat = 0;
                m_retry = 0;
                m_base = miss_paddr;
                new_profile();
            end
        end else if (m_bus) begin
            if (bus.wb_err_i) begin
                m_bus = 0;
                n_err++;
            end else if (kill) begin
                m_bus = 0;
                n_kill++;
            end else if (bus.wb_rty_i) begin
                m_bus = 0;
                if (m_retry == 3) n_err++;
                else begin
                    m_retry++;
                    m_gap = 1;
                    m_beat = 0;
                end
            end else if (bus.wb_ack_i) begin
                m_words[m_beat] = bus.wb_dat_i;
                if (m_beat == 7) begin
                    m_bus = 0;
                    m_tail = 1;
                    directed = 0;
                end else m_beat++;
            end
        end else if (m_gap) begin
            m_gap = 0;
            m_bus = 1;
        end else if (m_tail == 1) m_tail = 2;
        else begin
            m_tail = 0;
            n_done++;
        end
    endtask

    task automatic reset_test();
        q.delete();
        miss_req = 1'b0;
        kill = 1'b0;
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
        bus.wb_rty_i = 1'b0;
        #3 rst_n = 1'b1;
        #1;
        chk("async_rst_cyc", bus.wb_cyc_o, 0);
        chk("async_rst_stb", bus.wb_stb_o, 0);
        chk("async_rst_freeze", freeze, 0);
        @(negedge clk);
        chk("rst_line_data", line_data, 0);
        chk("rst_line_we", line_we, 0);
        chk("rst_done", refill_done, 0);
        rst_n = 1'b0;
        m_bus = 0;
        m_gap = 0;
        m_tail = 0;
        for (int i = 0; i < 8; i++) m_words[i] = '0;
        rst_done = 1;
    endtask

    // monitor: every cycle the driver queued an expectation, compare what the DUT presents
    initial forever begin
        @(negedge clk);
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("cyc", bus.wb_cyc_o, e.cyc);
            chk("stb", bus.wb_stb_o, e.cyc);
            if (e.cyc) begin
                chk("adr", bus.wb_adr_o, e.adr);
                chk("cti", bus.wb_cti_o, e.cti);
                chk("tied_we_sel_bte", {bus.wb_we_o, bus.wb_sel_o, bus.wb_bte_o}, 7'b0_1111_00);
            end
            chk("line_we", line_we, e.we);
            if (e.we) chk("line_data", line_data, e.line);
            chk("refill_done", refill_done, e.done);
            chk("refill_err", refill_err, e.err);
            chk("freeze", freeze, e.frz);
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) m_words[i] = '0;
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
        bus.wb_rty_i = 1'b0;
        bus.wb_dat_i = '0;
        #1 rst_n = 1'b1;
        #1;
        chk("reset_cyc", bus.wb_cyc_o, 0);
        chk("reset_adr_cti", {bus.wb_adr_o, bus.wb_cti_o}, 0);
        chk("reset_line_data", line_data, 0);
        chk("reset_pulses", {line_we, refill_done, refill_err, freeze}, 0);
        @(negedge clk);
        rst_n = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (!rst_done && c > 3000 && c < 5900 && m_bus && m_beat >= 3) reset_test();
            else step();
        end
        @(negedge clk);
        miss_req = 1'b0;
        #3;
        chk("queue_drained", 32'(q.size()), 0);
        $display("refills done %0d, errors %0d, kills %0d", n_done, n_err, n_kill);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
